// File: rtl/dense_neuron_mac.sv
// rtl/dense_neuron_mac.sv - streaming multiply-accumulate for one dense-layer neuron
// Takes N_INPUTS activation/weight beats, adds a bias, and holds the sum until downstream takes it.
module dense_neuron_mac #(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     data_in,
  input  logic signed [WIDTH-1:0]     weight_in,
  input  logic signed [2*WIDTH-1:0]   bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [4*WIDTH-1:0]   acc_out
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0] LAST = 8'(N_INPUTS - 1);

  state_t                      state;
  logic [7:0]                  cnt;
  logic signed [4*WIDTH-1:0]   acc;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [4*WIDTH-1:0]   prod_ext;
  logic signed [4*WIDTH-1:0]   bias_ext;

  assign prod     = data_in * weight_in;
  assign prod_ext = {{(2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign bias_ext = {{(2*WIDTH){bias[2*WIDTH-1]}}, bias};
  assign acc_out  = acc;

  // in_ready/out_valid are registered alongside the state so they decode nothing combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_valid && in_ready) begin
            acc <= ((state == IDLE) ? bias_ext : acc) + prod_ext;
            if (cnt == LAST) begin
              state     <= DONE;
              cnt       <= 8'd0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
              cnt   <= cnt + 8'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 8'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dense_neuron_mac.sv
// tb/tb_dense_neuron_mac.sv - bench for dense_neuron_mac
// Directed literal cases plus randomized traffic against a queue-based sum model.
module tb_dense_neuron_mac;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   data_in;
  logic signed [WIDTH-1:0]   weight_in;
  logic signed [2*WIDTH-1:0] bias;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [4*WIDTH-1:0] acc_out;

  dense_neuron_mac #(.WIDTH(WIDTH), .N_INPUTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .weight_in(weight_in), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: products of accepted beats collected in a queue, summed with the first beat's bias.
  int          q[$];
  longint      m_bias;
  bit          m_valid;
  logic [31:0] m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_valid = 1'b0;
      m_exp   = '0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (in_valid) begin
      longint s;
      if (q.size() == 0) m_bias = longint'(bias);
      q.push_back(int'(data_in) * int'(weight_in));
      if (q.size() == N) begin
        s = m_bias;
        foreach (q[i]) s += q[i];
        m_exp   = s[31:0];
        m_valid = 1'b1;
        q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("model_in_ready", {31'd0, in_ready}, {31'd0, !m_valid});
      if (m_valid) chk("model_acc_out", acc_out, m_exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input int w, input int b);
    in_valid  = 1'b1;
    data_in   = 8'(d);
    weight_in = 8'(w);
    bias      = 16'(b);
    step();
    in_valid  = 1'b0;
    data_in   = 8'($urandom);
    weight_in = 8'($urandom);
    bias      = 16'($urandom);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic basic_eval();
    beat(1, 10, 5);
    beat(2, 10, 999);
    beat(3, 10, -7);
    chk("basic_not_done_early", {31'd0, out_valid}, 32'd0);
    beat(4, 10, 1234);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    weight_in = '0;
    bias      = '0;
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_acc_out", acc_out, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // basic + backpressure
    basic_eval();
    chk("basic_out_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_acc_out", acc_out, 32'h0000_0069);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      step();
      chk("bp_acc_out", acc_out, 32'd105);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_result();
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

    // negative
    for (int i = 0; i < N; i++) beat(-128, 127, 0);
    chk("neg_acc_out", acc_out, 32'hFFFF_0200);
    release_result();

    // max magnitude
    for (int i = 0; i < N; i++) beat(-128, -128, 32767);
    chk("max_acc_out", acc_out, 32'h0001_7FFF);
    release_result();

    // gaps 1,0,0,1,0,1,1
    beat(1, 10, 5);
    step(); step();
    beat(2, 10, 0);
    step();
    beat(3, 10, 0);
    chk("gap_not_done_early", {31'd0, out_valid}, 32'd0);
    beat(4, 10, 0);
    chk("gap_out_valid", {31'd0, out_valid}, 32'd1);
    chk("gap_acc_out", acc_out, 32'd105);
    release_result();

    // reset mid-op
    beat(7, 9, 100);
    beat(-3, 5, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_acc_out", acc_out, 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    basic_eval();
    chk("rst_mid_acc_out_after", acc_out, 32'd105);
    release_result();

    // randomized traffic, checked every cycle by the model compare
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      data_in   = 8'($urandom);
      weight_in = 8'($urandom);
      bias      = 16'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dense_neuron_mac.md
DENSE_NEURON_MAC -- requirements
Module: dense_neuron_mac

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of each signed activation and weight.
REQ-002 Parameter: N_INPUTS, default 4, number of input beats per neuron evaluation, legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  data_in/weight_in beat present.
REQ-006 Port: in_ready  output  1  block can accept a beat.
REQ-007 Port: data_in  input  WIDTH  signed activation.
REQ-008 Port: weight_in  input  WIDTH  signed weight paired with data_in.
REQ-009 Port: bias  input  2*WIDTH  signed bias; sampled on the first accepted beat of an evaluation.
REQ-010 Port: out_valid  output  1  acc_out holds a finished sum.
REQ-011 Port: out_ready  input  1  downstream activation stage accepts acc_out.
REQ-012 Port: acc_out  output  4*WIDTH  signed pre-activation sum, the format the downstream ReLU stage consumes.

Function
REQ-013 The block SHALL implement the FSM states IDLE (no beats taken), ACCUM (1..N_INPUTS-1 beats taken) and DONE (result held).
REQ-014 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-016 Each accepted beat SHALL form the full-precision signed product data_in*weight_in (2*WIDTH bits) and sign-extend it to 4*WIDTH.
REQ-017 On the first beat (IDLE), acc SHALL load sext(bias)+sext(product); on later beats, acc SHALL load acc+sext(product).
REQ-018 Accumulation SHALL wrap modulo 2^(4*WIDTH), with no saturation and no overflow flag.
REQ-019 A beat counter SHALL count accepted beats; on acceptance of beat N_INPUTS the FSM SHALL enter DONE and the counter SHALL return to 0.
REQ-020 With N_INPUTS=1, the first beat SHALL go directly from IDLE to DONE.
REQ-021 out_valid SHALL be 1 exactly while in DONE, first asserted the cycle after the last beat is accepted (latency 1 cycle from last beat).
REQ-022 acc_out SHALL equal the accumulator register and SHALL be stable while out_valid && !out_ready.
REQ-023 On out_valid && out_ready, the FSM SHALL return to IDLE on that edge, and in_ready SHALL be 1 on the following cycle.
REQ-024 The block SHALL accept no beat in the out_ready handshake cycle, so evaluations never overlap.
REQ-025 Cycles with in_valid=0 in IDLE or ACCUM SHALL hold acc, the counter and the state unchanged, so gaps of any length are permitted.
REQ-026 data_in, weight_in and bias SHALL be ignored when no beat is accepted.

Reset
REQ-027 While rst_n=0, the block SHALL immediately force state=IDLE, counter=0, acc=0, acc_out=0 and out_valid=0, with in_ready=1 after release.
REQ-028 Reset asserted mid-evaluation (ACCUM or DONE) SHALL discard the partial or held sum, and the next evaluation SHALL start fresh with bias.
REQ-029 Deassertion of rst_n SHALL take effect on the first clock edge after release, with no spurious out_valid.

Verification
REQ-030 Basic: WIDTH=8, N=4, data 1,2,3,4, weights 10,10,10,10 back-to-back, bias=5 -> out_valid one cycle after the 4th beat, acc_out=105 (0x00000069).
REQ-031 Negative: data -128 x4, weights 127 x4, bias=0 -> acc_out=-65024 (0xFFFF0200).
REQ-032 Max magnitude: data -128 x4, weights -128 x4, bias=32767 -> acc_out=98303 (0x00017FFF).
REQ-033 Backpressure: after REQ-030, hold out_ready=0 for 3 cycles -> acc_out stays 105, out_valid=1, in_ready=0 throughout; out_ready=1 -> next cycle IDLE, in_ready=1.
REQ-034 Gaps: in_valid toggled 1,0,0,1,0,1,1 with the REQ-030 data -> same result 105, out_valid only after the 4th accepted beat.
REQ-035 Reset mid-op: after 2 beats, pulse rst_n low asynchronously mid-cycle -> out_valid=0 and acc_out=0 immediately; a following REQ-030 sequence yields 105.
